mealy_rr_sel: RTL
=================

MEALY_RR_SEL -- requirements
Module: mealy_rr_sel

Interface
REQ-001 Parameter W, default 3, data width of each channel and of y.
REQ-002 Parameter NCH, default 4, number of channels/states; legal range 2..16.
REQ-003 Parameter SW, default 2, state/index width; SHALL satisfy 2**SW >= NCH.
REQ-004 Parameter WRAP, default 1: 1 = wrap at ends, 0 = saturate at ends.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 i  in  1  advance request.
REQ-008 dir  in  1  advance direction: 0 = up (index+1), 1 = down (index-1).
REQ-009 ld  in  1  load request; priority over i.
REQ-010 ld_idx  in  SW  index to load.
REQ-011 d  in  NCH*W  flattened channel data; channel k occupies bits [k*W+W-1 : k*W].
REQ-012 y  out  W  Mealy data output.
REQ-013 idx  out  SW  current state index (registered).
REQ-014 edge  out  1  Mealy flag: advance requested at end of range in current direction.

Function
REQ-015 State SHALL be a registered index in 0..NCH-1; idx SHALL equal the state.
REQ-016 Next-state (nxt) SHALL be combinational, with this priority: ld, then i, then hold.
REQ-017 If ld=1 and ld_idx<NCH, nxt SHALL be ld_idx.
REQ-018 If ld=1 and ld_idx>=NCH, nxt SHALL be the current state; i is ignored that cycle.
REQ-019 Up advance (ld=0, i=1, dir=0), index < NCH-1: nxt SHALL be index+1.
REQ-020 Up advance at index NCH-1: nxt SHALL be 0 if WRAP=1, or NCH-1 if WRAP=0.
REQ-021 Down advance (ld=0, i=1, dir=1), index > 0: nxt SHALL be index-1.
REQ-022 Down advance at index 0: nxt SHALL be NCH-1 if WRAP=1, or 0 if WRAP=0.
REQ-023 With ld=0 and i=0, nxt SHALL equal the current state.
REQ-024 y SHALL be combinational and equal d channel nxt, in the same cycle as the inputs (zero latency).
REQ-025 y SHALL respond to any change of i, dir, ld, ld_idx, d or state without waiting for a clock edge.
REQ-026 edge SHALL be combinational and equal ld=0 & i=1 & (dir=0 & index=NCH-1 | dir=1 & index=0).
REQ-027 edge SHALL behave identically for either WRAP value.
REQ-028 The state register SHALL load nxt on every rising clk edge while rst=1.
REQ-029 With NCH=2, WRAP=1, dir=0 and ld=0, the block SHALL be a two-state toggle:
- state 0, i=1: go to 1, y=d1
- state 0, i=0: stay, y=d0
- state 1, i=1: go to 0, y=d0
- state 1, i=0: stay, y=d1
REQ-030 Unused index codes NCH..2**SW-1 SHALL never be reached; if present, the next edge SHALL force state 0.
REQ-031 No latches; all combinational outputs SHALL be fully assigned on every path.

Reset
REQ-032 rst=0 SHALL force state to 0 immediately, independent of clk.
REQ-033 During reset idx=0; y=d channel nxt computed from state 0, per REQ-024; edge per REQ-026.
REQ-034 Reset asserted mid-operation SHALL discard any pending advance or load.
REQ-035 The first rising clk edge after rst returns to 1 SHALL apply normal next-state rules.

Verification
REQ-036 Reset, NCH=4, d={3,2,1,0} (ch3..ch0):
- rst=0 asynchronously -> idx=0
- i=0 -> y=0
- i=1, dir=0 -> y=1 before the edge, idx=1 after it.
REQ-037 Up wrap, WRAP=1: four edges with i=1, dir=0 from idx=0 -> idx 1,2,3,0; edge=1 only in the cycle idx=3.
REQ-038 Down saturation, WRAP=0, idx=0, i=1, dir=1 -> edge=1, y=d0, idx stays 0.
REQ-039 Load:
- ld=1, ld_idx=2, i=1 -> y=d2, edge=0, idx=2 next cycle
- ld_idx=5, NCH=4 -> idx held.
REQ-040 Mid-operation reset: idx=3, pulse rst low between edges -> idx=0 immediately; next edge with i=1, dir=0 -> idx=1.
REQ-041 Two-state mode, NCH=2, W=3, m=d0=5, n=d1=2 -> y follows REQ-029 for all four state/i combinations.

Source files
------------

// File: rtl/mealy_rr_sel_if.sv
// mealy_rr_sel_if: request/load inputs, channel data and Mealy outputs of the selector
interface mealy_rr_sel_if #(
    parameter int W   = 3,
    parameter int NCH = 4,
    parameter int SW  = 2
);
    logic           i;
    logic           dir;
    logic           ld;
    logic [SW-1:0]  ld_idx;
    logic [NCH*W-1:0] d;
    logic [W-1:0]   y;
    logic [SW-1:0]  idx;
    logic           edge_flag;
    modport master (output i, dir, ld, ld_idx, d, input y, idx, edge_flag);
    modport slave  (input i, dir, ld, ld_idx, d, output y, idx, edge_flag);
endinterface

// File: rtl/mealy_rr_sel.sv
// mealy_rr_sel: registered channel index with load/advance, Mealy data select and end-of-range flag
module mealy_rr_sel #(
    parameter int W    = 3,
    parameter int NCH  = 4,
    parameter int SW   = 2,
    parameter int WRAP = 1
) (
    input logic           clk,
    input logic           rst,
    mealy_rr_sel_if.slave bus
);
    localparam logic [SW:0]   N    = (SW+1)'(NCH);
    localparam logic [SW-1:0] LAST = SW'(NCH - 1);
    logic [SW-1:0] state_q, state_d;
    logic          at_hi, at_lo;
    // index register; active-low asynchronous reset returns to channel 0
    always_ff @(posedge clk or negedge rst)
        if (!rst) state_q <= '0;
        else      state_q <= state_d;
    // next index (illegal code > load > advance > hold) and the Mealy outputs derived from it
    always_comb begin
        at_hi   = state_q == LAST;
        at_lo   = state_q == '0;
        state_d = state_q;
        if ({1'b0, state_q} >= N)
            state_d = '0;
        else if (bus.ld)
            state_d = ({1'b0, bus.ld_idx} < N) ? bus.ld_idx : state_q;
        else if (bus.i)
            state_d = bus.dir ? (at_lo ? (WRAP != 0 ? LAST : '0) : state_q - 1'b1)
                              : (at_hi ? (WRAP != 0 ? '0 : LAST) : state_q + 1'b1);
        bus.y         = bus.d[int'(state_d)*W +: W];
        bus.edge_flag = !bus.ld && bus.i && (bus.dir ? at_lo : at_hi);
    end
    assign bus.idx = state_q;
endmodule
